if_fetch_unit: RTL



---
 rtl/riscv_pkg.sv | 17 +
 rtl/if_fetch_unit_if.sv | 25 ++
 rtl/if_fetch_fifo.sv | 61 ++++++
 rtl/if_fetch_unit.sv | 91 +++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants.
// Used by the fetch unit, its buffer and the decode interface.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0]    PC_STEP         = 32'd4;
    localparam logic [XLEN-1:0]    RESET_PC_DEF    = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] IMEM_EMPTY_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-to-decode valid/ready handshake.
// master = fetch side, slave = decode side.
interface if_fetch_unit_if;
    import riscv_pkg::*;

    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [XLEN-1:0]    if_pc;

    modport master (
        output if_valid,
        output if_instr,
        output if_pc,
        input  if_ready
    );

    modport slave (
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output if_ready
    );

endinterface

// File: rtl/if_fetch_fifo.sv
// In-order fetch buffer: DEPTH entries, flush, simultaneous push/pop.
// A push into a full buffer is only taken when a pop frees a slot.
module if_fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr];

    // Pointer, occupancy and storage update; flush drops all entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr] <= wdata;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC register, redirect handling and fetch buffer.
// Optional IF_HALT_ON_ZERO_EN stops fetch on an all-zero instruction word.
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    if_fetch_unit_if.master          dec,
    output logic [$clog2(DEPTH):0]   buf_count,
    output logic                     halted
);

    logic [XLEN-1:0] pc_q;
    logic            halted_q;
    logic            zero_word;
    logic            pop;
    logic            push;
    logic            full;
    logic            empty;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;
    logic            unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

`ifdef IF_HALT_ON_ZERO_EN
    assign zero_word = (imem_rdata == IMEM_EMPTY_WORD);

    // Halt on an unprogrammed word; a redirect resumes fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            halted_q <= 1'b0;
        end else if (~halted_q & zero_word) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign zero_word = 1'b0;
    assign halted_q  = 1'b0;
`endif

    assign imem_addr = pc_q;
    assign halted    = halted_q;

    assign pop  = dec.if_valid & dec.if_ready;
    assign push = ~redirect_valid & ~halted_q & ~zero_word
                & (~full | pop);

    assign wr_entry.pc    = pc_q;
    assign wr_entry.instr = imem_rdata;

    // PC: redirect wins, otherwise advance on every accepted fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            pc_q <= pc_q + PC_STEP;
        end
    end

    if_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .count (buf_count),
        .full  (full),
        .empty (empty)
    );

    assign dec.if_valid = ~empty;
    assign dec.if_pc    = head.pc;
    assign dec.if_instr = head.instr;

endmodule
